// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_TIMERS down-counting timers (one-shot or periodic) with
// write-1-to-clear pending interrupts, plus a 64-bit free-running stable counter
// whose high word is read through a snapshot taken on a low-word read.
module csr_timer_bank #(
   parameter int unsigned NUM_TIMERS = 4,
   parameter int unsigned TIMESIZE   = 32,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned CNT_W      = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  csr_we,
   input  logic [ADDR_W-1:0]     csr_waddr,
   input  logic [31:0]           csr_wdata,
   input  logic [31:0]           csr_wmask,
   input  logic                  csr_re,
   input  logic [ADDR_W-1:0]     csr_raddr,
   output logic [31:0]           csr_rdata,
   input  logic                  timer_stall,
   output logic [NUM_TIMERS-1:0] timer_irq,
   output logic                  irq_any
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SUB_W  = 2;
   localparam int unsigned CH_W   = ADDR_W - SUB_W;
   localparam int unsigned HI_LSB = 32;

   localparam logic [SUB_W-1:0]  SUB_CFG     = 2'd0;
   localparam logic [SUB_W-1:0]  SUB_VAL     = 2'd1;
   localparam logic [SUB_W-1:0]  SUB_CLR     = 2'd2;
   localparam logic [ADDR_W-1:0] CNT_LO_ADDR = ADDR_W'(4 * NUM_TIMERS);
   localparam logic [ADDR_W-1:0] CNT_HI_ADDR = ADDR_W'(4 * NUM_TIMERS + 1);

   // CFG layout: bit0 En, bit1 Periodic, [TIMESIZE-1:2] InitVal
   logic [NUM_TIMERS-1:0][TIMESIZE-1:0] cfg_q;
   logic [NUM_TIMERS-1:0][TIMESIZE-1:0] cfg_d;
   logic [NUM_TIMERS-1:0][TIMESIZE-1:0] val_q;
   logic [NUM_TIMERS-1:0][TIMESIZE-1:0] val_d;
   logic [NUM_TIMERS-1:0]               pend_d;
   logic [NUM_TIMERS-1:0]               cfg_wr;
   logic [NUM_TIMERS-1:0]               clr_wr;
   logic [NUM_TIMERS-1:0]               fire;
   logic [CNT_W-1:0]                    cnt_q;
   logic [DATA_W-1:0]                   shadow_hi_q;
   logic [DATA_W-1:0]                   wdata_m;
   logic [CH_W-1:0]                     wr_ch;
   logic [CH_W-1:0]                     rd_ch;
   logic [SUB_W-1:0]                    wr_sub;
   logic [SUB_W-1:0]                    rd_sub;

   assign wdata_m = csr_wdata & csr_wmask;
   assign wr_ch   = csr_waddr[ADDR_W-1:SUB_W];
   assign wr_sub  = csr_waddr[SUB_W-1:0];
   assign rd_ch   = csr_raddr[ADDR_W-1:SUB_W];
   assign rd_sub  = csr_raddr[SUB_W-1:0];

   // Per-channel write decode; a CLR only counts when masked data bit0 is set
   always_comb begin
      cfg_wr = '0;
      clr_wr = '0;
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
         cfg_wr[i] = csr_we && (wr_ch == CH_W'(i)) && (wr_sub == SUB_CFG);
         clr_wr[i] = csr_we && (wr_ch == CH_W'(i)) && (wr_sub == SUB_CLR) && wdata_m[0];
      end
   end

   // Channel next state: CFG write beats counting/firing, firing beats CLR
   always_comb begin
      logic [TIMESIZE-1:0] nv;
      nv     = '0;
      cfg_d  = cfg_q;
      val_d  = val_q;
      pend_d = timer_irq;
      fire   = '0;
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
         if (cfg_wr[i]) begin
            nv       = (cfg_q[i] & ~csr_wmask[TIMESIZE-1:0]) | wdata_m[TIMESIZE-1:0];
            cfg_d[i] = nv;
            val_d[i] = {nv[TIMESIZE-1:2], 2'b00};
         end else if (!timer_stall && cfg_q[i][0]) begin
            if (val_q[i] != '0) begin
               val_d[i] = val_q[i] - TIMESIZE'(1);
            end else begin
               fire[i]   = 1'b1;
               pend_d[i] = 1'b1;
               if (cfg_q[i][1]) begin
                  val_d[i] = {cfg_q[i][TIMESIZE-1:2], 2'b00};
               end else begin
                  cfg_d[i][0] = 1'b0;
               end
            end
         end
         if (clr_wr[i] && !fire[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // Channel registers and interrupt outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_q     <= '0;
         val_q     <= '0;
         timer_irq <= '0;
         irq_any   <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         val_q     <= val_d;
         timer_irq <= pend_d;
         irq_any   <= |pend_d;
      end
   end

   // Stable counter and high-word snapshot captured on a low-word read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         shadow_hi_q <= '0;
      end else begin
         if (!timer_stall) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (csr_re && (csr_raddr == CNT_LO_ADDR)) begin
            shadow_hi_q <= cnt_q[CNT_W-1:HI_LSB];
         end
      end
   end

   // Combinational read mux; unmapped, reserved and CLR addresses read 0
   always_comb begin
      csr_rdata = '0;
      for (int i = 0; i < int'(NUM_TIMERS); i++) begin
         if (rd_ch == CH_W'(i)) begin
            if (rd_sub == SUB_CFG) begin
               csr_rdata = DATA_W'(cfg_q[i]);
            end else if (rd_sub == SUB_VAL) begin
               csr_rdata = DATA_W'(val_q[i]);
            end
         end
      end
      if (csr_raddr == CNT_LO_ADDR) begin
         csr_rdata = cnt_q[DATA_W-1:0];
      end else if (csr_raddr == CNT_HI_ADDR) begin
         csr_rdata = shadow_hi_q;
      end
   end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Bench for csr_timer_bank: directed scenarios plus a randomized run checked
// against a field-level behavioural model of the timers and stable counter.
`timescale 1ns/1ps
module tb_csr_timer_bank;

   localparam int NT     = 4;
   localparam int TS     = 32;
   localparam int AW     = 6;
   localparam int HALF   = 100;
   localparam int CNT_LO = 4 * NT;
   localparam int CNT_HI = 4 * NT + 1;
   localparam longint unsigned TSMASK = (64'd1 << TS) - 64'd1;

   logic          clk = 1'b0;
   logic          reset;
   logic          csr_we;
   logic [AW-1:0] csr_waddr;
   logic [31:0]   csr_wdata;
   logic [31:0]   csr_wmask;
   logic          csr_re;
   logic [AW-1:0] csr_raddr;
   logic [31:0]   csr_rdata;
   logic          timer_stall;
   logic [NT-1:0] timer_irq;
   logic          irq_any;

   int checks = 0;
   int errors = 0;

   // Model state, kept as separate fields rather than a packed register
   bit              m_en   [NT];
   bit              m_per  [NT];
   longint unsigned m_init [NT];
   longint unsigned m_val  [NT];
   bit              m_pend [NT];
   longint unsigned m_cnt;
   longint unsigned m_shadow;

   csr_timer_bank #(.NUM_TIMERS(NT), .TIMESIZE(TS), .ADDR_W(AW), .CNT_W(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .csr_we      (csr_we),
      .csr_waddr   (csr_waddr),
      .csr_wdata   (csr_wdata),
      .csr_wmask   (csr_wmask),
      .csr_re      (csr_re),
      .csr_raddr   (csr_raddr),
      .csr_rdata   (csr_rdata),
      .timer_stall (timer_stall),
      .timer_irq   (timer_irq),
      .irq_any     (irq_any)
   );

   always #HALF clk = ~clk;

   initial begin
      #(2 * HALF * 60000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic longint unsigned m_cfg_word(int ch);
      return ((m_init[ch] * 4) + (m_per[ch] ? 2 : 0) + (m_en[ch] ? 1 : 0)) & TSMASK;
   endfunction

   function automatic logic [31:0] model_read(int a);
      if (a < 4 * NT) begin
         if (a % 4 == 0) return 32'(m_cfg_word(a / 4));
         if (a % 4 == 1) return 32'(m_val[a / 4]);
         return 32'd0;
      end
      if (a == CNT_LO) return 32'(m_cnt);
      if (a == CNT_HI) return 32'(m_shadow);
      return 32'd0;
   endfunction

   function automatic logic [NT-1:0] model_irq();
      logic [NT-1:0] v;
      for (int ch = 0; ch < NT; ch++) v[ch] = m_pend[ch];
      return v;
   endfunction

   task automatic model_reset();
      for (int ch = 0; ch < NT; ch++) begin
         m_en[ch] = 0; m_per[ch] = 0; m_init[ch] = 0; m_val[ch] = 0; m_pend[ch] = 0;
      end
      m_cnt = 0;
      m_shadow = 0;
   endtask

   // Apply one clock edge's worth of rules to the model from the current inputs
   task automatic model_step();
      longint unsigned w;
      bit fired;
      for (int ch = 0; ch < NT; ch++) begin
         fired = 0;
         if (csr_we && int'(csr_waddr) == 4 * ch) begin
            w = ((m_cfg_word(ch) & ~longint'(csr_wmask)) | longint'(csr_wdata & csr_wmask)) & TSMASK;
            m_en[ch]   = (w % 2) == 1;
            m_per[ch]  = ((w / 2) % 2) == 1;
            m_init[ch] = w / 4;
            m_val[ch]  = m_init[ch] * 4;
         end else if (!timer_stall && m_en[ch]) begin
            if (m_val[ch] > 0) begin
               m_val[ch] = m_val[ch] - 1;
            end else begin
               fired = 1;
               m_pend[ch] = 1;
               if (m_per[ch]) m_val[ch] = m_init[ch] * 4;
               else m_en[ch] = 0;
            end
         end
         if (csr_we && int'(csr_waddr) == 4 * ch + 2 && (csr_wdata & csr_wmask & 32'd1) != 0 && !fired)
            m_pend[ch] = 0;
      end
      if (csr_re && int'(csr_raddr) == CNT_LO) m_shadow = m_cnt >> 32;
      if (!timer_stall) m_cnt = m_cnt + 1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      csr_we = 0; csr_waddr = '0; csr_wdata = '0; csr_wmask = '0;
      csr_re = 0; csr_raddr = '0; timer_stall = 0;
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [31:0] m);
      csr_we = 1; csr_waddr = AW'(a); csr_wdata = d; csr_wmask = m;
      cycle();
      csr_we = 0;
   endtask

   task automatic rd(input int a, output logic [31:0] d);
      csr_raddr = AW'(a);
      #1;
      d = csr_rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      idle();
      reset = 1;
      model_reset();
      repeat (3) @(negedge clk);
      for (int a = 0; a < (1 << AW); a++) begin
         rd(a, d);
         checks++;
         if (d !== 32'd0) begin errors++; $display("FAIL reset_read addr=%0d: got %h expected 0", a, d); end
      end
      checks++;
      if (timer_irq !== '0 || irq_any !== 1'b0) begin
         errors++; $display("FAIL reset_irq: got irq=%b any=%b expected 0/0", timer_irq, irq_any);
      end
      reset = 0;
      cycle();
      rd(CNT_LO, d);
      checks++;
      if (d !== 32'd1) begin errors++; $display("FAIL reset_cnt_first: got %0d expected 1", d); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      wr(0, 32'h11, 32'hFFFF_FFFF);
      for (int k = 0; k <= 16; k++) begin
         rd(1, d);
         checks++;
         if (d !== 32'(16 - k) || timer_irq[0] !== 1'b0) begin
            errors++; $display("FAIL oneshot_count k=%0d: got val=%0d irq=%b expected val=%0d irq=0", k, d, timer_irq[0], 16 - k);
         end
         cycle();
      end
      checks++;
      if (timer_irq[0] !== 1'b1 || irq_any !== 1'b1) begin
         errors++; $display("FAIL oneshot_fire: got irq=%b any=%b expected 1/1", timer_irq[0], irq_any);
      end
      repeat (3) cycle();
      rd(0, d);
      checks++;
      if (d !== 32'h10) begin errors++; $display("FAIL oneshot_cfg: got %h expected 10", d); end
      rd(1, d);
      checks++;
      if (d !== 32'd0 || timer_irq[0] !== 1'b1) begin
         errors++; $display("FAIL oneshot_hold: got val=%0d irq=%b expected 0/1", d, timer_irq[0]);
      end
   endtask

   task automatic test_periodic();
      int e, first, second;
      wr(4, 32'h0B, 32'hFFFF_FFFF);
      e = 0; first = -1; second = -1;
      for (int k = 0; k < 40 && first < 0; k++) begin
         cycle(); e++;
         if (timer_irq[1]) first = e;
      end
      checks++;
      if (first != 9) begin errors++; $display("FAIL periodic_first: fired at edge %0d expected 9", first); end
      wr(6, 32'd1, 32'd1); e++;
      checks++;
      if (timer_irq[1] !== 1'b0) begin errors++; $display("FAIL periodic_clr: got %b expected 0", timer_irq[1]); end
      for (int k = 0; k < 40 && second < 0; k++) begin
         cycle(); e++;
         if (timer_irq[1]) second = e;
      end
      checks++;
      if (second != first + 9) begin
         errors++; $display("FAIL periodic_interval: fired at edge %0d expected %0d", second, first + 9);
      end
      repeat (8) begin cycle(); e++; end
      wr(6, 32'd1, 32'hFFFF_FFFF); e++;
      checks++;
      if (timer_irq[1] !== 1'b1) begin errors++; $display("FAIL periodic_clr_on_fire: got %b expected 1", timer_irq[1]); end
      wr(6, 32'd1, 32'hFFFF_FFFF); e++;
      checks++;
      if (timer_irq[1] !== 1'b0) begin errors++; $display("FAIL periodic_clr_after: got %b expected 0", timer_irq[1]); end
   endtask

   task automatic test_stall();
      logic [31:0] d, lo_frozen;
      wr(8, 32'h09, 32'hFFFF_FFFF);
      repeat (3) cycle();
      rd(9, d);
      checks++;
      if (d !== 32'd5) begin errors++; $display("FAIL stall_pre: got %0d expected 5", d); end
      timer_stall = 1;
      lo_frozen = 32'(m_cnt);
      for (int k = 0; k < 10; k++) begin
         cycle();
         rd(9, d);
         checks++;
         if (d !== 32'd5) begin errors++; $display("FAIL stall_val k=%0d: got %0d expected 5", k, d); end
         rd(CNT_LO, d);
         checks++;
         if (d !== lo_frozen) begin errors++; $display("FAIL stall_cnt k=%0d: got %h expected %h", k, d, lo_frozen); end
      end
      timer_stall = 0;
      cycle();
      rd(9, d);
      checks++;
      if (d !== 32'd4) begin errors++; $display("FAIL stall_resume: got %0d expected 4", d); end
   endtask

   task automatic test_cfg_priority();
      logic [31:0] d;
      wr(2, 32'd1, 32'd1);
      checks++;
      if (timer_irq[0] !== 1'b0) begin errors++; $display("FAIL prio_clr0: got %b expected 0", timer_irq[0]); end
      wr(0, 32'h1, 32'hFFFF_FFFF);
      for (int k = 0; k < 3; k++) begin
         wr(0, 32'h1, 32'hFFFF_FFFF);
         rd(0, d);
         checks++;
         if (timer_irq[0] !== 1'b0 || d !== 32'h1) begin
            errors++; $display("FAIL prio_cfg_wins k=%0d: got irq=%b cfg=%h expected 0/1", k, timer_irq[0], d);
         end
      end
      cycle();
      rd(0, d);
      checks++;
      if (timer_irq[0] !== 1'b1 || d !== 32'h0) begin
         errors++; $display("FAIL prio_fire_init0: got irq=%b cfg=%h expected 1/0", timer_irq[0], d);
      end
      wr(2, 32'h1, 32'hFFFF_FFFE);
      wr(2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      checks++;
      if (timer_irq[0] !== 1'b1) begin errors++; $display("FAIL clr_bit0_masked: got %b expected 1", timer_irq[0]); end
      wr(2, 32'h1, 32'h1);
      checks++;
      if (timer_irq[0] !== 1'b0) begin errors++; $display("FAIL clr_bit0: got %b expected 0", timer_irq[0]); end
   endtask

   task automatic test_snapshot();
      logic [31:0] d;
      force dut.cnt_q = 64'h0000_0000_FFFF_FFFE;
      #1;
      release dut.cnt_q;
      m_cnt = 64'h0000_0000_FFFF_FFFE;
      csr_re = 1;
      rd(CNT_LO, d);
      checks++;
      if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL snap_lo: got %h expected fffffffe", d); end
      cycle();
      csr_re = 0;
      repeat (3) cycle();
      rd(CNT_LO, d);
      checks++;
      if (d !== 32'd2) begin errors++; $display("FAIL snap_lo_live: got %h expected 2", d); end
      rd(CNT_HI, d);
      checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL snap_hi: got %h expected 0 (live hi is 1)", d); end
      csr_re = 1;
      rd(CNT_LO, d);
      cycle();
      csr_re = 0;
      rd(CNT_HI, d);
      checks++;
      if (d !== 32'd1) begin errors++; $display("FAIL snap_hi_update: got %h expected 1", d); end
   endtask

   task automatic test_mask_reset();
      logic [31:0] d;
      wr(12, 32'h0C, 32'hFFFF_FFFF);
      wr(12, 32'hFF, 32'h3);
      rd(12, d);
      checks++;
      if (d !== 32'h0F) begin errors++; $display("FAIL mask_cfg: got %h expected 0f", d); end
      rd(13, d);
      checks++;
      if (d !== 32'd12) begin errors++; $display("FAIL mask_val: got %0d expected 12", d); end
      repeat (4) cycle();
      rd(13, d);
      checks++;
      if (d !== 32'd8) begin errors++; $display("FAIL mask_count: got %0d expected 8", d); end
      reset = 1;
      #1;
      model_reset();
      rd(13, d);
      checks++;
      if (d !== 32'd0 || timer_irq !== '0 || irq_any !== 1'b0) begin
         errors++; $display("FAIL midreset: got val=%0d irq=%b any=%b expected 0", d, timer_irq, irq_any);
      end
      @(negedge clk);
      reset = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         checks++;
         if (timer_irq !== '0 || irq_any !== 1'b0) begin
            errors++; $display("FAIL post_reset_irq k=%0d: got %b expected 0", k, timer_irq);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] d, e;
      for (int n = 0; n < 400; n++) begin
         csr_we      = ($urandom_range(0, 1) == 1);
         csr_waddr   = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 4 * NT + 3));
         csr_wdata   = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h3F) : $urandom;
         csr_wmask   = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
         csr_re      = ($urandom_range(0, 1) == 1);
         csr_raddr   = AW'($urandom_range(0, 4 * NT + 2));
         timer_stall = ($urandom_range(0, 9) == 0);
         cycle();
         checks++;
         if (timer_irq !== model_irq() || irq_any !== (|model_irq())) begin
            errors++; $display("FAIL rand_irq n=%0d: got %b/%b expected %b", n, timer_irq, irq_any, model_irq());
         end
         for (int a = 0; a < (1 << AW); a++) begin
            rd(a, d);
            e = model_read(a);
            checks++;
            if (d !== e) begin errors++; $display("FAIL rand_read n=%0d addr=%0d: got %h expected %h", n, a, d, e); end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_stall();
      test_cfg_priority();
      test_snapshot();
      test_mask_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
